pc_next_unit: RTL and testbench

Program-counter stage of the single-cycle MIPS datapath. Holds the architectural PC and selects the next PC from sequential, branch, jump and jump-register sources. It sits directly downstream of `shift_left_2` and consumes its word-aligned branch offset, `shifted_address`, as the PC-relative displacement. It also tracks a two-state run/halt machine so fetch can be frozen on `halt` or on a misaligned register target.

---
 rtl/mips_pkg.sv | 6 +
 rtl/pc_next_unit_if.sv | 24 ++
 rtl/pc_adder32.sv | 15 +
 rtl/pc_next_unit.sv | 46 ++++
 tb/tb_pc_next_unit.sv | 109 ++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and state encoding for the PC stage.
package mips_pkg;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;
endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: next-PC select inputs and PC/status outputs of the PC stage.
interface pc_next_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] shifted_address;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        misaligned;
  modport master (
    output stall, branch_taken, shifted_address, jump, jump_index, jr, jr_target, halt,
    input  pc, pc_plus4, fetch_valid, halted, misaligned
  );
  modport slave (
    input  stall, branch_taken, shifted_address, jump, jump_index, jr, jr_target, halt,
    output pc, pc_plus4, fetch_valid, halted, misaligned
  );
endinterface

// File: rtl/pc_adder32.sv
// pc_adder32: 32-bit ripple-carry adder, carry-out discarded (modulo 2^32).
module pc_adder32 (
  input  logic [31:0] a0,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic [31:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i] = a0[i] ^ b[i] ^ c[i];
    if (i < 31) begin : g_carry
      assign c[i+1] = (a0[i] & b[i]) | (c[i] & (a0[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: architectural PC register, next-PC select and run/halt state.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           reset,
  pc_next_unit_if.slave  bus
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4, br_target;
  logic        mis_q, mis_d, active, jr_bad, stop;
  pc_adder32 u_inc (.a0(pc_q),     .b(PC_INC),              .sum(pc_plus4));
  pc_adder32 u_br  (.a0(pc_plus4), .b(bus.shifted_address), .sum(br_target));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end
  // halt outranks a misaligned JR, so only the latter raises the sticky flag
  always_comb begin
    active  = (state_q == RUN) && !bus.stall;
    jr_bad  = bus.jr && (bus.jr_target[1:0] != 2'b00);
    stop    = bus.halt || jr_bad;
    state_d = (active && stop) ? HALTED : state_q;
    mis_d   = mis_q | (active && !bus.halt && jr_bad);
    pc_d    = (!active || stop) ? pc_q :
              bus.jr            ? bus.jr_target :
              bus.jump          ? {pc_plus4[31:28], bus.jump_index, 2'b00} :
              bus.branch_taken  ? br_target : pc_plus4;
  end
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_plus4;
    bus.fetch_valid = (state_q == RUN);
    bus.halted      = (state_q == HALTED);
    bus.misaligned  = mis_q;
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed plan plus randomized run checked against a behavioural PC model.
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   fails = 0;
  logic [31:0] m_pc;
  logic        m_halted, m_mis;
  pc_next_unit_if bus ();
  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic br, input logic [31:0] sa,
                     input logic j, input logic [25:0] ji, input logic r, input logic [31:0] rt,
                     input logic h);
    reset = rst; bus.stall = st; bus.branch_taken = br; bus.shifted_address = sa;
    bus.jump = j; bus.jump_index = ji; bus.jr = r; bus.jr_target = rt; bus.halt = h;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0;
    end else if (!m_halted && !st) begin
      if (h) m_halted = 1'b1;
      else if (r && (rt % 4 != 0)) begin m_halted = 1'b1; m_mis = 1'b1; end
      else if (r) m_pc = rt;
      else if (j) m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, ji} * 32'd4);
      else if (br) m_pc = m_pc + 32'd4 + sa;
      else m_pc = m_pc + 32'd4;
    end
    #1;
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, !m_halted});
    chk("halted", {31'b0, bus.halted}, {31'b0, m_halted});
    chk("misaligned", {31'b0, bus.misaligned}, {31'b0, m_mis});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  initial begin
    m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0;
    cyc(1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
    chk("reset_pc", bus.pc, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("seq_pc", bus.pc, 32'(i * 4));
    end
    chk("seq_fetch_valid", {31'b0, bus.fetch_valid}, 32'd1);
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 26'h0, 0, 32'h0, 0);
    chk("branch_back", bus.pc, 32'h0000_000C);
    idle();
    chk("back_to_10", bus.pc, 32'h0000_0010);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 32'hFFFF_FFF8, 0, 26'h0, 0, 32'h0, 0);
      chk("stall_hold", bus.pc, 32'h0000_0010);
    end
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 26'h0, 0, 32'h0, 0);
    chk("branch_after_stall", bus.pc, 32'h0000_000C);
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h4000_0000, 0);
    chk("jr_aligned", bus.pc, 32'h4000_0000);
    cyc(0, 0, 1, 32'h0000_0100, 1, 26'h000_0040, 0, 32'h0, 0);
    chk("jump_wins", bus.pc, 32'h4000_0100);
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h0000_0202, 0);
    chk("mis_pc_hold", bus.pc, 32'h4000_0100);
    chk("mis_flag", {31'b0, bus.misaligned}, 32'd1);
    chk("mis_halted", {31'b0, bus.halted}, 32'd1);
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h0000_0800, 0);
    cyc(0, 0, 0, 32'h0, 1, 26'h3FF_FFFF, 0, 32'h0, 0);
    chk("halted_ignores", bus.pc, 32'h4000_0100);
    cyc(1, 0, 0, 32'h0, 1, 26'h1, 0, 32'h0, 1);
    chk("reset_clears_pc", bus.pc, 32'h0);
    chk("reset_clears_mis", {31'b0, bus.misaligned}, 32'd0);
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0);
    idle();
    chk("wrap", bus.pc, 32'h0);
    cyc(0, 0, 1, 32'h40, 1, 26'h5, 1, 32'h8, 1);
    chk("halt_pc", bus.pc, 32'h0);
    chk("halt_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("halt_no_mis", {31'b0, bus.misaligned}, 32'd0);
    cyc(1, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
    for (int i = 0; i < 400; i++) begin
      logic rst;
      logic [31:0] rt;
      rst = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      cyc(rst, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 5) == 0, 26'($urandom), $urandom_range(0, 7) == 0, rt,
          $urandom_range(0, 29) == 0);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
